board_clear_ctl: RTL and testbench
==================================

Name: board_clear_ctl

Overview:
- Line-clear sequencer for the 10x20 playfield board RAM (one 10-bit word per row, row 0 = top, bit c = column c occupied).
- Started by the piece controller when a falling piece locks. Scans the board for full rows, removes them, compacts the rows above downwards, and zero-fills the top.
- Maintains lines/level/score statistics and feeds the level value back to the fall-delay logic.
- Sole master of the board RAM port while busy.

Parameters:
- ROWS, 20, board height; row index width 5 bits.
- COLS, 10, board width and RAM word width.
- LINES_PER_LEVEL, 10, cleared lines per level increment.
- MAX_LEVEL, 9, level saturation value.
- FLASH_CYCLES, 16000000, flash hold time in pclk cycles (only used with CLEAR_FLASH_EN).

Ports:
- pclk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to run a clear pass; ignored unless state is IDLE
- stats_clr  in  1  clears score, level and lines_total; honoured only in IDLE; start wins if both are asserted
- mem_addr  out  5  board RAM row address
- mem_rd_data  in  10  RAM read data, valid 1 cycle after mem_addr
- mem_wr_en  out  1  RAM write strobe
- mem_wr_data  out  10  RAM write data
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at the end of every pass
- cleared_last  out  5  number of rows removed by the last pass
- full_mask  out  20  bit r set if row r was full in the last scan
- lines_total  out  16  total lines cleared, saturating at 16'hFFFF
- level  out  4  current level, 0..MAX_LEVEL
- score  out  20  score, saturating at 20'hFFFFF
- flash  out  1  high during the flash hold; tied 0 without the macro

Behaviour:
- Reset: state IDLE; all outputs 0; internal pointers, counters and mask cleared. Reset mid-pass aborts immediately; RAM contents are then undefined and the owner re-initialises the board.
- States and transitions:
  - IDLE: on start, rd_ptr=ROWS-1, mask=0, go to SC_RD.
  - SC_RD: mem_addr=rd_ptr; go to SC_EV.
  - SC_EV: mask[rd_ptr] = &mem_rd_data. If rd_ptr==0, go to SC_END; else rd_ptr-1, go to SC_RD.
  - SC_END: n = popcount(mask); cleared_last=n; full_mask=mask. If n==0, go to DONE (no RAM writes). Else go to FLASH (with macro) or CP_INIT.
  - CP_INIT: rd_ptr=wr_ptr=ROWS-1; go to CP_RD.
  - CP_RD: mem_addr=rd_ptr; go to CP_EV.
  - CP_EV: if mask[rd_ptr], the row is dropped. Else if rd_ptr!=wr_ptr, latch the data and go to CP_WR. Else wr_ptr-1 (row already in place, no write). After handling row 0, go to FILL; otherwise rd_ptr-1 and go to CP_RD.
  - CP_WR: mem_wr_en=1, mem_addr=wr_ptr, mem_wr_data=latched row; wr_ptr-1. Go to FILL if row 0 has been read, else CP_RD.
  - FILL: write 0 to rows wr_ptr down to 0, one row per cycle, exactly n writes. Go to SCORE after row 0.
  - SCORE: score += pts(n)*(level+1), where pts is 1→40, 2→100, 3→300, ≥4→1200; uses the level in effect before this pass. lines_total += n; lvl_cnt += n. Go to LVL.
  - LVL: while lvl_cnt >= LINES_PER_LEVEL, subtract LINES_PER_LEVEL and increment level (saturates at MAX_LEVEL; subtraction continues), one step per cycle. Then go to DONE.
  - DONE: done=1 for one cycle; go to IDLE.
- mem_wr_en is high only in CP_WR and FILL. mem_addr outside the read/write states is 0.
- Arithmetic: all sums are computed wide, then saturated. Pointer decrements never underflow because the row-0 check precedes them.
- Boundaries:
  - Empty board: pass completes in 2*ROWS+2 cycles with no writes.
  - All 20 rows full: n=20, no CP_WR writes, 20 FILL writes, level steps twice.
  - start during busy is ignored. done and start in the same cycle: start is honoured on the following IDLE cycle only if still asserted.

Optional Feature:
- CLEAR_FLASH_EN defined: after SC_END with n>0, state FLASH holds flash=1 for FLASH_CYCLES cycles (counter from 0 to FLASH_CYCLES-1), then goes to CP_INIT. full_mask is valid throughout, so the renderer can blink the cleared rows.
- Not defined: no FLASH state, flash tied 0, SC_END goes directly to CP_INIT.

Test Plan:
- Empty board, start → done after 42 cycles from start; no mem_wr_en; cleared_last=0; score=0.
- Rows 19 and 17 full (3FF), row 18=001, row 16=200, rest 0, level 0 → rows 19=001, 18=200, 17..0=0; cleared_last=2; full_mask=0xA0000; score=100; lines_total=2.
- Rows 16..19 full, level 2 → score +=3600; lines_total=4; all rows 0.
- Preload lvl_cnt by clearing 9 single lines, then a 2-line clear → level=1, lvl_cnt=1. Repeat until level 9 → level stays at 9.
- rst asserted in CP_WR → next cycle state IDLE, busy=0, mem_wr_en=0, score=0. start during busy → no second pass and only one done pulse.
- With CLEAR_FLASH_EN, FLASH_CYCLES=5, one full row → flash high for exactly 5 cycles before the first compaction write. Without the macro → flash stays 0.

Source files
------------

// File: rtl/board_clear_ctl_if.sv
// Board RAM port bundle for the line-clear sequencer.
// The master side drives address and write strobe/data. The slave side
// (the RAM) returns read data one cycle after the address.
interface board_clear_ctl_if #(
    parameter int AW = 5,
    parameter int DW = 10
);
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data;
    logic          mem_wr_en;
    logic [DW-1:0] mem_wr_data;

    modport master (
        output mem_addr,
        output mem_wr_en,
        output mem_wr_data,
        input  mem_rd_data
    );

    modport slave (
        input  mem_addr,
        input  mem_wr_en,
        input  mem_wr_data,
        output mem_rd_data
    );
endinterface

// File: rtl/board_clear_ctl.sv
// Line-clear sequencer for the 10x20 playfield board RAM.
// A pass scans every row, bottom first, and records which rows are full.
// It then copies the surviving rows downwards and zero-fills the top.
// Finally it updates score, lines and level.
// Optional macro CLEAR_FLASH_EN inserts a flash hold before compaction,
// so the renderer can blink the rows in full_mask.
module board_clear_ctl #(
    parameter int ROWS            = 20,
    parameter int COLS            = 10,
    parameter int LINES_PER_LEVEL = 10,
    parameter int MAX_LEVEL       = 9
`ifdef CLEAR_FLASH_EN
    ,
    parameter int FLASH_CYCLES    = 16000000
`endif
) (
    input  logic                pclk,
    input  logic                rst,
    input  logic                start,
    input  logic                stats_clr,
    board_clear_ctl_if.master   ram,
    output logic                busy,
    output logic                done,
    output logic [4:0]          cleared_last,
    output logic [ROWS-1:0]     full_mask,
    output logic [15:0]         lines_total,
    output logic [3:0]          level,
    output logic [19:0]         score,
    output logic                flash
);
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_SC_RD   = 4'd1;
    localparam logic [3:0] S_SC_EV   = 4'd2;
    localparam logic [3:0] S_SC_END  = 4'd3;
    localparam logic [3:0] S_CP_INIT = 4'd4;
    localparam logic [3:0] S_CP_RD   = 4'd5;
    localparam logic [3:0] S_CP_EV   = 4'd6;
    localparam logic [3:0] S_CP_WR   = 4'd7;
    localparam logic [3:0] S_FILL    = 4'd8;
    localparam logic [3:0] S_SCORE   = 4'd9;
    localparam logic [3:0] S_LVL     = 4'd10;
    localparam logic [3:0] S_DONE    = 4'd11;
`ifdef CLEAR_FLASH_EN
    localparam logic [3:0] S_FLASH   = 4'd12;
    localparam int         FW         = $clog2(FLASH_CYCLES + 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_CYCLES - 1);
`endif

    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [5:0] LPL      = 6'(LINES_PER_LEVEL);
    localparam logic [3:0] MAXL     = 4'(MAX_LEVEL);

    // Number of set bits in the full-row mask.
    function automatic logic [4:0] popcount(input logic [ROWS-1:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < ROWS; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

    // Base points for a pass that removed n rows.
    function automatic logic [10:0] pts(input logic [4:0] n);
        logic [10:0] p;
        case (n)
            5'd0:    p = 11'd0;
            5'd1:    p = 11'd40;
            5'd2:    p = 11'd100;
            5'd3:    p = 11'd300;
            default: p = 11'd1200;
        endcase
        return p;
    endfunction

    logic [3:0]      state_r;
    logic [4:0]      rd_ptr_r;
    logic [4:0]      wr_ptr_r;
    logic [ROWS-1:0] mask_r;
    logic            rd_last_r;
    logic [5:0]      lvl_cnt_r;
    logic [4:0]      mem_addr_r;
    logic            mem_wr_en_r;
    logic [COLS-1:0] mem_wr_data_r;
    logic            busy_r;
    logic            done_r;
    logic [4:0]      cleared_last_r;
    logic [ROWS-1:0] full_mask_r;
    logic [15:0]     lines_r;
    logic [3:0]      level_r;
    logic [19:0]     score_r;
`ifdef CLEAR_FLASH_EN
    logic            flash_r;
    logic [FW-1:0]   flash_cnt_r;
`endif

    logic [4:0]  n_scan_s;
    logic [4:0]  level_p1_s;
    logic [15:0] score_add_s;
    logic [20:0] score_sum_s;
    logic [16:0] lines_sum_s;
    logic [5:0]  lvl_sum_s;
    logic [4:0]  rd_dec_s;
    logic [4:0]  wr_dec_s;

    // Wide sums for the statistics update and the pointer decrements.
    always_comb begin
        n_scan_s    = popcount(mask_r);
        level_p1_s  = {1'b0, level_r} + 5'd1;
        score_add_s = {5'd0, pts(cleared_last_r)} * {11'd0, level_p1_s};
        score_sum_s = {1'b0, score_r} + {5'd0, score_add_s};
        lines_sum_s = {1'b0, lines_r} + {12'd0, cleared_last_r};
        lvl_sum_s   = lvl_cnt_r + {1'b0, cleared_last_r};
        rd_dec_s    = rd_ptr_r - 5'd1;
        wr_dec_s    = wr_ptr_r - 5'd1;
    end

    // Sequencer. RAM outputs are registered one state ahead, so they line up with the state that owns them.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_r        <= S_IDLE;
            rd_ptr_r       <= 5'd0;
            wr_ptr_r       <= 5'd0;
            mask_r         <= '0;
            rd_last_r      <= 1'b0;
            lvl_cnt_r      <= 6'd0;
            mem_addr_r     <= 5'd0;
            mem_wr_en_r    <= 1'b0;
            mem_wr_data_r  <= '0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            cleared_last_r <= 5'd0;
            full_mask_r    <= '0;
            lines_r        <= 16'd0;
            level_r        <= 4'd0;
            score_r        <= 20'd0;
`ifdef CLEAR_FLASH_EN
            flash_r        <= 1'b0;
            flash_cnt_r    <= '0;
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        busy_r     <= 1'b1;
                        rd_ptr_r   <= LAST_ROW;
                        mask_r     <= '0;
                        mem_addr_r <= LAST_ROW;
                        state_r    <= S_SC_RD;
                    end else if (stats_clr) begin
                        score_r   <= 20'd0;
                        level_r   <= 4'd0;
                        lines_r   <= 16'd0;
                        lvl_cnt_r <= 6'd0;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_SC_RD: begin
                    mem_addr_r <= 5'd0;
                    state_r    <= S_SC_EV;
                end
                S_SC_EV: begin
                    mask_r[rd_ptr_r] <= &ram.mem_rd_data;
                    if (rd_ptr_r == 5'd0) begin
                        state_r <= S_SC_END;
                    end else begin
                        rd_ptr_r   <= rd_dec_s;
                        mem_addr_r <= rd_dec_s;
                        state_r    <= S_SC_RD;
                    end
                end
                S_SC_END: begin
                    cleared_last_r <= n_scan_s;
                    full_mask_r    <= mask_r;
                    if (n_scan_s == 5'd0) begin
                        done_r  <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
`ifdef CLEAR_FLASH_EN
                        flash_r     <= 1'b1;
                        flash_cnt_r <= '0;
                        state_r     <= S_FLASH;
`else
                        state_r     <= S_CP_INIT;
`endif
                    end
                end
`ifdef CLEAR_FLASH_EN
                S_FLASH: begin
                    if (flash_cnt_r == FLASH_LAST) begin
                        flash_r <= 1'b0;
                        state_r <= S_CP_INIT;
                    end else begin
                        flash_cnt_r <= flash_cnt_r + 1'b1;
                    end
                end
`endif
                S_CP_INIT: begin
                    rd_ptr_r   <= LAST_ROW;
                    wr_ptr_r   <= LAST_ROW;
                    mem_addr_r <= LAST_ROW;
                    state_r    <= S_CP_RD;
                end
                S_CP_RD: begin
                    mem_addr_r <= 5'd0;
                    state_r    <= S_CP_EV;
                end
                S_CP_EV: begin
                    rd_last_r <= (rd_ptr_r == 5'd0);
                    if (rd_ptr_r != 5'd0) begin
                        rd_ptr_r <= rd_dec_s;
                    end else begin
                        rd_ptr_r <= rd_ptr_r;
                    end
                    if (!mask_r[rd_ptr_r] && (rd_ptr_r != wr_ptr_r)) begin
                        // Surviving row that must move down: write it next cycle.
                        mem_wr_en_r   <= 1'b1;
                        mem_addr_r    <= wr_ptr_r;
                        mem_wr_data_r <= ram.mem_rd_data;
                        state_r       <= S_CP_WR;
                    end else begin
                        // Dropped row, or surviving row already in place.
                        if (!mask_r[rd_ptr_r]) begin
                            wr_ptr_r <= wr_dec_s;
                        end else begin
                            wr_ptr_r <= wr_ptr_r;
                        end
                        if (rd_ptr_r == 5'd0) begin
                            mem_wr_en_r   <= 1'b1;
                            mem_addr_r    <= mask_r[rd_ptr_r] ? wr_ptr_r : wr_dec_s;
                            mem_wr_data_r <= '0;
                            state_r       <= S_FILL;
                        end else begin
                            mem_addr_r <= rd_dec_s;
                            state_r    <= S_CP_RD;
                        end
                    end
                end
                S_CP_WR: begin
                    wr_ptr_r      <= wr_dec_s;
                    mem_wr_data_r <= '0;
                    if (rd_last_r) begin
                        mem_addr_r <= wr_dec_s;
                        state_r    <= S_FILL;
                    end else begin
                        mem_wr_en_r <= 1'b0;
                        mem_addr_r  <= rd_ptr_r;
                        state_r     <= S_CP_RD;
                    end
                end
                S_FILL: begin
                    if (wr_ptr_r == 5'd0) begin
                        mem_wr_en_r <= 1'b0;
                        mem_addr_r  <= 5'd0;
                        state_r     <= S_SCORE;
                    end else begin
                        wr_ptr_r   <= wr_dec_s;
                        mem_addr_r <= wr_dec_s;
                    end
                end
                S_SCORE: begin
                    score_r   <= score_sum_s[20] ? 20'hFFFFF : score_sum_s[19:0];
                    lines_r   <= lines_sum_s[16] ? 16'hFFFF : lines_sum_s[15:0];
                    lvl_cnt_r <= lvl_sum_s;
                    state_r   <= S_LVL;
                end
                S_LVL: begin
                    if (lvl_cnt_r >= LPL) begin
                        lvl_cnt_r <= lvl_cnt_r - LPL;
                        level_r   <= (level_r == MAXL) ? level_r : level_r + 4'd1;
                    end else begin
                        done_r  <= 1'b1;
                        state_r <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    mem_wr_en_r <= 1'b0;
                    mem_addr_r  <= 5'd0;
                    done_r      <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

    assign ram.mem_addr    = mem_addr_r;
    assign ram.mem_wr_en   = mem_wr_en_r;
    assign ram.mem_wr_data = mem_wr_data_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign cleared_last    = cleared_last_r;
    assign full_mask       = full_mask_r;
    assign lines_total     = lines_r;
    assign level           = level_r;
    assign score           = score_r;
`ifdef CLEAR_FLASH_EN
    assign flash           = flash_r;
`else
    assign flash           = 1'b0;
`endif
endmodule

// File: tb/tb_board_clear_ctl.sv
// Scoreboard bench for board_clear_ctl: each start pushes the hand-computed
// outcome of the pass, and a monitor compares it against the DUT when done pulses.
module tb_board_clear_ctl;
    logic        pclk;
    logic        rst;
    logic        start;
    logic        stats_clr;
    logic        busy;
    logic        done;
    logic [4:0]  cleared_last;
    logic [19:0] full_mask;
    logic [15:0] lines_total;
    logic [3:0]  level;
    logic [19:0] score;
    logic        flash;

`ifdef CLEAR_FLASH_EN
    localparam int FL_EXP = 5;
`else
    localparam int FL_EXP = 0;
`endif

    board_clear_ctl_if #(.AW(5), .DW(10)) ram ();

    board_clear_ctl #(
        .ROWS(20), .COLS(10), .LINES_PER_LEVEL(10), .MAX_LEVEL(9)
`ifdef CLEAR_FLASH_EN
        , .FLASH_CYCLES(5)
`endif
    ) dut (
        .pclk(pclk), .rst(rst), .start(start), .stats_clr(stats_clr),
        .ram(ram), .busy(busy), .done(done), .cleared_last(cleared_last),
        .full_mask(full_mask), .lines_total(lines_total), .level(level),
        .score(score), .flash(flash)
    );

    typedef struct {
        logic [4:0]   cl;
        logic [19:0]  mask;
        logic [19:0]  score;
        logic [15:0]  lines;
        logic [3:0]   level;
        int           writes;
        int           lat;
        logic [199:0] board;
        int           start_cyc;
    } exp_t;

    exp_t exp_q[$];
    logic [9:0] board [0:19];
    int cyc;
    int checks;
    int errors;
    int wr_cnt;
    int fl_cnt;
    int fl_at_wr;

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    // Synchronous-read board RAM model.
    always @(posedge pclk) begin
        ram.mem_rd_data <= board[ram.mem_addr];
        if (ram.mem_wr_en) board[ram.mem_addr] = ram.mem_wr_data;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [199:0] rows_full(input logic [19:0] m);
        logic [199:0] b;
        b = '0;
        for (int r = 0; r < 20; r++) b[r*10 +: 10] = m[r] ? 10'h3FF : 10'h000;
        return b;
    endfunction

    // Monitor: counts writes and flash cycles, then checks a pass when done pulses.
    always @(negedge pclk) begin
        if (rst) begin
            wr_cnt = 0;
            fl_cnt = 0;
            fl_at_wr = 0;
        end else begin
            if (flash) fl_cnt++;
            if (ram.mem_wr_en) begin
                if (wr_cnt == 0) fl_at_wr = fl_cnt;
                wr_cnt++;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done pulse, expected none");
                end else begin
                    exp_t e;
                    logic [199:0] cur;
                    e = exp_q.pop_front();
                    for (int r = 0; r < 20; r++) cur[r*10 +: 10] = board[r];
                    chk("cleared_last", 32'(cleared_last), 32'(e.cl));
                    chk("full_mask", 32'(full_mask), 32'(e.mask));
                    chk("score", 32'(score), 32'(e.score));
                    chk("lines_total", 32'(lines_total), 32'(e.lines));
                    chk("level", 32'(level), 32'(e.level));
                    chk("write_count", wr_cnt, e.writes);
                    chk("flash_cycles", fl_cnt, (e.cl != 5'd0) ? FL_EXP : 0);
                    if (e.writes > 0) chk("flash_before_write", fl_at_wr, FL_EXP);
                    if (e.lat >= 0) chk("latency", cyc - e.start_cyc, e.lat);
                    checks++;
                    if (cur !== e.board) begin
                        errors++;
                        $display("FAIL board: got %h, expected %h", cur, e.board);
                    end
                end
                wr_cnt = 0;
                fl_cnt = 0;
                fl_at_wr = 0;
            end
        end
    end

    task automatic wait_done(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge pclk);
            if (done === 1'b1) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done, expected done within 400 cycles", name);
        end
        @(negedge pclk);
    endtask

    task automatic run_pass(input logic [199:0] pre, input logic [4:0] cl,
                            input logic [19:0] msk, input logic [19:0] sc,
                            input logic [15:0] ln, input logic [3:0] lv,
                            input int wr, input int lat,
                            input logic [199:0] post, input bit with_clr);
        exp_t e;
        for (int r = 0; r < 20; r++) board[r] = pre[r*10 +: 10];
        @(negedge pclk);
        e.cl = cl; e.mask = msk; e.score = sc; e.lines = ln; e.level = lv;
        e.writes = wr; e.lat = lat; e.board = post; e.start_cyc = cyc;
        exp_q.push_back(e);
        start = 1'b1;
        stats_clr = with_clr;
        @(negedge pclk);
        start = 1'b0;
        stats_clr = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        wait_done("pass");
    endtask

    initial begin
        logic [199:0] zero_b;
        logic [199:0] b_pre;
        logic [199:0] b_post;
        bit           got;
        zero_b = '0;
        for (int r = 0; r < 20; r++) board[r] = 10'h000;
        rst = 1'b1;
        start = 1'b0;
        stats_clr = 1'b0;
        repeat (3) @(negedge pclk);
        rst = 1'b0;
        @(negedge pclk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cleared", 32'(cleared_last), 32'd0);
        chk("rst_mask", 32'(full_mask), 32'd0);
        chk("rst_lines", 32'(lines_total), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_flash", 32'(flash), 32'd0);
        chk("rst_wr_en", 32'(ram.mem_wr_en), 32'd0);
        chk("rst_addr", 32'(ram.mem_addr), 32'd0);

        // Empty board: 42-cycle pass, no writes.
        run_pass(zero_b, 5'd0, 20'h00000, 20'd0, 16'd0, 4'd0, 0, 42, zero_b, 1'b0);

        // Rows 19 and 17 full, 18=001, 16=200.
        b_pre = '0;
        b_pre[19*10 +: 10] = 10'h3FF;
        b_pre[18*10 +: 10] = 10'h001;
        b_pre[17*10 +: 10] = 10'h3FF;
        b_pre[16*10 +: 10] = 10'h200;
        b_post = '0;
        b_post[19*10 +: 10] = 10'h001;
        b_post[18*10 +: 10] = 10'h200;
        run_pass(b_pre, 5'd2, 20'hA0000, 20'd100, 16'd2, 4'd0, 20, -1, b_post, 1'b0);

        // stats_clr in IDLE.
        @(negedge pclk);
        stats_clr = 1'b1;
        @(negedge pclk);
        stats_clr = 1'b0;
        chk("clr_score", 32'(score), 32'd0);
        chk("clr_lines", 32'(lines_total), 32'd0);
        chk("clr_level", 32'(level), 32'd0);

        // Nine single-line clears; the second has stats_clr alongside start (start wins).
        for (int k = 1; k <= 9; k++) begin
            run_pass(rows_full(20'h80000), 5'd1, 20'h80000, 20'(40 * k), 16'(k), 4'd0,
                     20, -1, zero_b, (k == 2));
        end
        run_pass(rows_full(20'hC0000), 5'd2, 20'hC0000, 20'd460, 16'd11, 4'd1, 20, -1, zero_b, 1'b0);
        run_pass(rows_full(20'hF0000), 5'd4, 20'hF0000, 20'd2860, 16'd15, 4'd1, 20, -1, zero_b, 1'b0);
        run_pass(rows_full(20'hF0000), 5'd4, 20'hF0000, 20'd5260, 16'd19, 4'd1, 20, -1, zero_b, 1'b0);
        run_pass(rows_full(20'h80000), 5'd1, 20'h80000, 20'd5340, 16'd20, 4'd2, 20, -1, zero_b, 1'b0);
        // Four lines at level 2: +3600.
        run_pass(rows_full(20'hF0000), 5'd4, 20'hF0000, 20'd8940, 16'd24, 4'd2, 20, -1, zero_b, 1'b0);
        // Whole board full: 20 fill writes, level steps twice; then saturate at 9.
        run_pass(rows_full(20'hFFFFF), 5'd20, 20'hFFFFF, 20'd12540, 16'd44, 4'd4, 20, -1, zero_b, 1'b0);
        run_pass(rows_full(20'hFFFFF), 5'd20, 20'hFFFFF, 20'd18540, 16'd64, 4'd6, 20, -1, zero_b, 1'b0);
        run_pass(rows_full(20'hFFFFF), 5'd20, 20'hFFFFF, 20'd26940, 16'd84, 4'd8, 20, -1, zero_b, 1'b0);
        run_pass(rows_full(20'hFFFFF), 5'd20, 20'hFFFFF, 20'd37740, 16'd104, 4'd9, 20, -1, zero_b, 1'b0);
        run_pass(rows_full(20'hFFFFF), 5'd20, 20'hFFFFF, 20'd49740, 16'd124, 4'd9, 20, -1, zero_b, 1'b0);

        // Reset during the first compaction write aborts the pass.
        for (int r = 0; r < 20; r++) board[r] = b_pre[r*10 +: 10];
        @(negedge pclk);
        start = 1'b1;
        @(negedge pclk);
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge pclk);
            if (ram.mem_wr_en === 1'b1) got = 1'b1;
        end
        chk("abort_saw_write", 32'(got), 32'd1);
        rst = 1'b1;
        @(negedge pclk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_wr_en", 32'(ram.mem_wr_en), 32'd0);
        chk("abort_score", 32'(score), 32'd0);
        chk("abort_level", 32'(level), 32'd0);
        rst = 1'b0;

        // start while busy is ignored: exactly one pass, one done.
        for (int r = 0; r < 20; r++) board[r] = 10'h000;
        @(negedge pclk);
        begin
            exp_t e;
            e.cl = 5'd0; e.mask = 20'd0; e.score = 20'd0; e.lines = 16'd0; e.level = 4'd0;
            e.writes = 0; e.lat = 42; e.board = zero_b; e.start_cyc = cyc;
            exp_q.push_back(e);
        end
        start = 1'b1;
        @(negedge pclk);
        start = 1'b0;
        repeat (5) @(negedge pclk);
        start = 1'b1;
        @(negedge pclk);
        start = 1'b0;
        wait_done("busy_start");
        repeat (60) @(negedge pclk);
        chk("busy_idle_after", 32'(busy), 32'd0);
        chk("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
